// File: rtl/cc_atlas_encoder.sv
// Atlas-bus C&C word serialiser: one 59-bit word per CLRCLK frame,
// addresses sent round-robin from a per-address frequency bank.
module cc_atlas_encoder #(
  parameter int NUM_ADDR = 2
) (
  input  logic        CBCLK,
  input  logic        reset,
  input  logic        CLRCLK,
  input  logic        cfg_wr,
  input  logic [3:0]  cfg_addr,
  input  logic [31:0] cfg_freq,
  input  logic        PTT,
  input  logic [3:0]  clock_select,
  input  logic [6:0]  OC,
  input  logic        MODE,
  input  logic        PGA,
  input  logic        DITHER,
  input  logic        RAND,
  input  logic [1:0]  ATTEN,
  input  logic [1:0]  TX_relay,
  input  logic        Rout,
  input  logic [1:0]  RX_relay,
  output logic        CC,
  output logic [3:0]  frame_addr,
  output logic        busy,
  output logic        overrun
);

  localparam int AW = (NUM_ADDR > 1) ? $clog2(NUM_ADDR) : 1;
  localparam int DEPTH = 1 << AW;
  localparam logic [3:0] LAST = 4'(NUM_ADDR - 1);
  localparam logic [4:0] NADDR = 5'(NUM_ADDR);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t state, state_nx;

  logic        clrclk_q;
  logic        fall;
  logic        start;
  logic [3:0]  ptr;
  logic [31:0] bank [DEPTH];
  logic [58:0] word;
  logic [58:0] sreg;
  logic [5:0]  cnt;

  assign fall = clrclk_q & ~CLRCLK;

  assign word = {
    PTT, ptr, bank[ptr[AW-1:0]],
    clock_select, OC, MODE, PGA,
    DITHER, RAND, ATTEN, TX_relay,
    Rout, RX_relay
  };

  always_ff @(posedge CBCLK) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // busy still high in IDLE marks the cleanup cycle; no new frame then
  always_comb begin
    state_nx = state;
    start    = 1'b0;
    unique case (state)
      IDLE: begin
        if (fall && !busy) begin
          start    = 1'b1;
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == 6'd0) state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge CBCLK) begin
    if (reset) begin
      clrclk_q   <= 1'b0;
      CC         <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
      frame_addr <= 4'd0;
      ptr        <= 4'd0;
      sreg       <= '0;
      cnt        <= 6'd0;
      for (int i = 0; i < DEPTH; i++) bank[i] <= '0;
    end else begin
      clrclk_q <= CLRCLK;
      overrun  <= fall & busy;
      if (cfg_wr && ({1'b0, cfg_addr} < NADDR))
        bank[cfg_addr[AW-1:0]] <= cfg_freq;
      if (start) begin
        sreg       <= word;
        CC         <= word[58];
        frame_addr <= ptr;
        busy       <= 1'b1;
        cnt        <= 6'd57;
        ptr        <= (ptr == LAST) ? 4'd0 : ptr + 4'd1;
      end else if (state == SHIFT) begin
        CC <= sreg[cnt];
        if (cnt != 6'd0) cnt <= cnt - 6'd1;
      end else if (busy) begin
        CC   <= 1'b0;
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cc_atlas_encoder.sv
// Scoreboard bench for cc_atlas_encoder: driver queues expected words,
// monitor deserialises CC at decoder timing and compares.
module tb_cc_atlas_encoder;

  logic        CBCLK = 1'b0;
  logic        reset;
  logic        CLRCLK;
  logic        cfg_wr;
  logic [3:0]  cfg_addr;
  logic [31:0] cfg_freq;
  logic        PTT;
  logic [3:0]  clock_select;
  logic [6:0]  OC;
  logic        MODE;
  logic        PGA;
  logic        DITHER;
  logic        RAND;
  logic [1:0]  ATTEN;
  logic [1:0]  TX_relay;
  logic        Rout;
  logic [1:0]  RX_relay;
  logic        CC;
  logic [3:0]  frame_addr;
  logic        busy;
  logic        overrun;

  cc_atlas_encoder #(.NUM_ADDR(2)) dut (
    .CBCLK(CBCLK),
    .reset(reset),
    .CLRCLK(CLRCLK),
    .cfg_wr(cfg_wr),
    .cfg_addr(cfg_addr),
    .cfg_freq(cfg_freq),
    .PTT(PTT),
    .clock_select(clock_select),
    .OC(OC),
    .MODE(MODE),
    .PGA(PGA),
    .DITHER(DITHER),
    .RAND(RAND),
    .ATTEN(ATTEN),
    .TX_relay(TX_relay),
    .Rout(Rout),
    .RX_relay(RX_relay),
    .CC(CC),
    .frame_addr(frame_addr),
    .busy(busy),
    .overrun(overrun)
  );

  always #5 CBCLK = ~CBCLK;

  typedef struct packed {
    logic [58:0] word;
    logic [3:0]  addr;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   errors = 0;
  logic mon_en = 1'b0;
  logic abort_ok = 1'b0;
  logic ovr_exp = 1'b0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [58:0] pack(
    input logic ptt, input logic [3:0] a, input logic [31:0] f,
    input logic [3:0] cs, input logic [6:0] oc, input logic md,
    input logic pg, input logic dt, input logic rn,
    input logic [1:0] at, input logic [1:0] tx, input logic ro,
    input logic [1:0] rx);
    return {ptt, a, f, cs, oc, md, pg, dt, rn, at, tx, ro, rx};
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge CBCLK);
      #1;
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] f);
    cfg_wr = 1'b1;
    cfg_addr = a;
    cfg_freq = f;
    cyc(1);
    cfg_wr = 1'b0;
  endtask

  // leaves CLRCLK low; the next posedge is E1
  task automatic arm(input logic push, input logic [58:0] w,
                     input logic [3:0] a);
    exp_t t;
    CLRCLK = 1'b1;
    cyc(32);
    CLRCLK = 1'b0;
    t.word = w;
    t.addr = a;
    if (push) q.push_back(t);
  endtask

  task automatic frame(input logic [58:0] w, input logic [3:0] a);
    arm(1'b1, w, a);
    cyc(32);
  endtask

  // bit k is sampled at E(60-k): one bit per cycle from the cycle after E1
  initial begin : monitor
    logic [58:0] sh;
    int nb;
    logic collecting;
    logic post_chk;
    exp_t e;
    sh = '0;
    nb = 0;
    collecting = 1'b0;
    post_chk = 1'b0;
    forever begin
      @(negedge CBCLK);
      if (mon_en) begin
        chk("overrun", overrun, ovr_exp);
        if (collecting) begin
          if (!busy) begin
            if (!abort_ok) chk("busy_width", nb, 59);
            collecting = 1'b0;
          end else begin
            sh = {sh[57:0], CC};
            nb++;
            if (nb == 59) begin
              collecting = 1'b0;
              post_chk = 1'b1;
              if (q.size() == 0) begin
                chk("frame_pending", q.size(), 1);
              end else begin
                e = q.pop_front();
                chk("frame_word", sh, e.word);
                chk("frame_addr", frame_addr, e.addr);
              end
            end
          end
        end else if (post_chk) begin
          chk("post_cc", CC, 0);
          chk("post_busy", busy, 0);
          post_chk = 1'b0;
        end else if (busy) begin
          collecting = 1'b1;
          sh = {58'd0, CC};
          nb = 1;
        end else begin
          chk("idle_cc", CC, 0);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    reset = 1'b1;
    CLRCLK = 1'b0;
    cfg_wr = 1'b0;
    cfg_addr = 4'd0;
    cfg_freq = 32'd0;
    PTT = 1'b0;
    clock_select = 4'd0;
    OC = 7'd0;
    MODE = 1'b0;
    PGA = 1'b0;
    DITHER = 1'b0;
    RAND = 1'b0;
    ATTEN = 2'd0;
    TX_relay = 2'd0;
    Rout = 1'b0;
    RX_relay = 2'd0;
    cyc(3);
    chk("reset_cc", CC, 0);
    chk("reset_busy", busy, 0);
    chk("reset_overrun", overrun, 0);
    chk("reset_frame_addr", frame_addr, 0);
    reset = 1'b0;
    mon_en = 1'b1;

    wr(4'd0, 32'h00A0_0000);
    wr(4'd1, 32'h0123_4567);
    PTT = 1'b1;
    RX_relay = 2'b10;

    frame(59'h400280000000002, 4'd0);
    frame(pack(1, 4'd1, 32'h0123_4567, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2), 4'd1);
    frame(pack(1, 4'd0, 32'h00A0_0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2), 4'd0);

    // level inputs toggled mid-frame must not reach the word
    clock_select = 4'hA;
    OC = 7'h55;
    MODE = 1'b1;
    PGA = 1'b1;
    DITHER = 1'b1;
    RAND = 1'b1;
    ATTEN = 2'b01;
    TX_relay = 2'b11;
    Rout = 1'b1;
    arm(1'b1, pack(1, 4'd1, 32'h0123_4567, 4'hA, 7'h55, 1, 1, 1, 1,
                   2'b01, 2'b11, 1, 2'b10), 4'd1);
    cyc(1);
    DITHER = 1'b0;
    ATTEN = 2'b10;
    OC = 7'd0;
    cyc(31);
    clock_select = 4'd0;
    MODE = 1'b0;
    PGA = 1'b0;
    RAND = 1'b0;
    ATTEN = 2'd0;
    TX_relay = 2'd0;
    Rout = 1'b0;

    // write to the address being snapshotted on E1
    arm(1'b1, pack(1, 4'd0, 32'h00A0_0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2),
        4'd0);
    cfg_wr = 1'b1;
    cfg_addr = 4'd0;
    cfg_freq = 32'hFFFF_FFFF;
    cyc(1);
    cfg_wr = 1'b0;
    cyc(5);
    wr(4'd5, 32'hDEAD_BEEF);
    cyc(26);
    frame(pack(1, 4'd1, 32'h0123_4567, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2), 4'd1);
    frame(pack(1, 4'd0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2), 4'd0);

    // short frame: second fall at E41
    arm(1'b1, pack(1, 4'd1, 32'h0123_4567, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2),
        4'd1);
    cyc(1);
    CLRCLK = 1'b1;
    cyc(39);
    CLRCLK = 1'b0;
    cyc(1);
    ovr_exp = 1'b1;
    chk("overrun_pulse", overrun, 1);
    cyc(1);
    ovr_exp = 1'b0;
    chk("overrun_clear", overrun, 0);
    cyc(30);
    PTT = 1'b0;
    frame(pack(0, 4'd0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2), 4'd0);

    // reset at E30 of an address-1 frame
    arm(1'b0, '0, 4'd0);
    cyc(29);
    abort_ok = 1'b1;
    reset = 1'b1;
    cyc(1);
    chk("midreset_cc", CC, 0);
    chk("midreset_busy", busy, 0);
    chk("midreset_frame_addr", frame_addr, 0);
    chk("midreset_overrun", overrun, 0);
    cyc(1);
    reset = 1'b0;
    abort_ok = 1'b0;
    frame(pack(0, 4'd0, 32'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2), 4'd0);
    frame(pack(0, 4'd1, 32'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2), 4'd1);

    cyc(40);
    chk("queue_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
